// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   Serial receive front end for the core's input instruction path. Receives
//   8N1 frames on an asynchronous serial line and queues each good byte in a
//   show-ahead FIFO so nothing is lost while the consumer is stalled.
//
// Parameters
//   CLK_PER_BIT  clock cycles per serial bit (>= 4)
//   DEPTH_LOG2   log2 of the FIFO depth
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   rxd        in   raw serial line, asynchronous, idle high
//   rx_pop     in   consumer takes rx_data this cycle
//   rx_data    out  FIFO head byte, meaningful only while rx_valid=1
//   rx_valid   out  FIFO non-empty
//   rx_count   out  number of bytes held (0 .. 2**DEPTH_LOG2)
//   overrun    out  sticky: a good byte was dropped because the FIFO was full
//   frame_err  out  sticky: a stop bit was sampled low
//   err_clr    in   clears overrun and frame_err (a coincident new error wins)
module uart_rx_buffer #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned DEPTH_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic                  rx_pop,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  err_clr
);

  localparam int unsigned CW    = $clog2(CLK_PER_BIT);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned NW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // --------------------------------------------------------------------------
  // Input synchroniser: two flops, reset to the idle (high) line level so a
  // reset never looks like a start bit by itself.
  // --------------------------------------------------------------------------
  logic rxd_meta_q;
  logic rxd_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  logic [7:0]    shift_q, shift_d;

  logic          byte_push;
  logic          frame_evt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;

    unique case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // Half a bit into the start bit: still low means a real frame,
      // high means a glitch and the line is ignored.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // From here every sample is a full bit period after the previous
      // one, so all samples stay at bit centres. LSB arrives first and is
      // shifted down from the top.
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Stop bit is sampled at its centre and IDLE is re-entered right
      // away, leaving half a bit of slack before the next start edge.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    byte_push = 1'b0;
    frame_evt = 1'b0;
    if (state_q == S_STOP && cnt_q == CNT_LAST) begin
      byte_push = rxd_s_q;
      frame_evt = ~rxd_s_q;
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO
  // --------------------------------------------------------------------------
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q,  wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q,  rptr_d;
  logic [NW-1:0]         count_q, count_d;

  logic pop_fire;
  logic push_acc;
  logic full;
  logic ovr_evt;

  assign full     = (count_q == CNT_FULL);
  assign pop_fire = rx_pop && (count_q != '0);
  // A pop in the same cycle frees the slot the push needs, so full+push+pop
  // is accepted and the count stays at depth.
  assign push_acc = byte_push && (!full || pop_fire);
  assign ovr_evt  = byte_push && full && !pop_fire;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_acc) begin
      wptr_d = wptr_q + DEPTH_LOG2'(1);
    end
    if (pop_fire) begin
      rptr_d = rptr_q + DEPTH_LOG2'(1);
    end
    unique case ({push_acc, pop_fire})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem_q[wptr_q] <= shift_q;
    end
  end

  assign rx_valid = (count_q != '0);
  assign rx_count = count_q;
  assign rx_data  = rx_valid ? mem_q[rptr_q] : '0;

  // --------------------------------------------------------------------------
  // Sticky error flags: a new event takes priority over err_clr.
  // --------------------------------------------------------------------------
  logic overrun_q, overrun_d;
  logic ferr_q,    ferr_d;

  always_comb begin
    overrun_d = overrun_q;
    ferr_d    = ferr_q;
    if (err_clr) begin
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
    end
    if (ovr_evt) begin
      overrun_d = 1'b1;
    end
    if (frame_evt) begin
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign overrun   = overrun_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed testbench for uart_rx_buffer with an 8-cycle bit period and a
// 4-entry FIFO.
module tb_uart_rx_buffer;

  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rx_pop;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overrun;
  logic       frame_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_buffer #(
    .CLK_PER_BIT (CPB),
    .DEPTH_LOG2  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_pop    (rx_pop),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame. The receiver samples the stop bit on the 79th edge
  // after the start bit is driven; pop_at_push raises rx_pop for that edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_push);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB - 2);
    rx_pop = pop_at_push;
    tick(1);
    rx_pop = 1'b0;
    tick(1);
    rxd = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_eq(tag, {24'd0, rx_data}, {24'd0, exp});
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"},  {24'd0, rx_data}, 32'h0);
    check_eq({tag, "_valid"}, {31'd0, rx_valid}, 32'h0);
    check_eq({tag, "_count"}, {29'd0, rx_count}, 32'h0);
    check_eq({tag, "_ovr"},   {31'd0, overrun},  32'h0);
    check_eq({tag, "_ferr"},  {31'd0, frame_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    rxd     = 1'b1;
    rx_pop  = 1'b0;
    err_clr = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(3);

    // 1: single byte, then pop
    send_frame(8'hA5, 1'b1, 1'b0);
    check_eq("t1_valid", {31'd0, rx_valid}, 32'h1);
    check_eq("t1_data",  {24'd0, rx_data},  32'hA5);
    check_eq("t1_count", {29'd0, rx_count}, 32'h1);
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0;
    check_eq("t1_valid_after_pop", {31'd0, rx_valid}, 32'h0);
    check_eq("t1_count_after_pop", {29'd0, rx_count}, 32'h0);
    // pop while empty must do nothing
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0;
    check_eq("t1_empty_pop_count", {29'd0, rx_count}, 32'h0);

    // 2: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
    end
    check_eq("t2_count",   {29'd0, rx_count}, 32'h4);
    check_eq("t2_overrun", {31'd0, overrun},  32'h1);
    pop_check("t2_pop1", 8'h01);
    pop_check("t2_pop2", 8'h02);
    pop_check("t2_pop3", 8'h03);
    pop_check("t2_pop4", 8'h04);
    check_eq("t2_count_empty", {29'd0, rx_count}, 32'h0);
    check_eq("t2_overrun_sticky", {31'd0, overrun}, 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("t2_overrun_clr", {31'd0, overrun}, 32'h0);

    // 3: full FIFO, push coincides with pop
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    check_eq("t3_full_count", {29'd0, rx_count}, 32'h4);
    check_eq("t3_head",       {24'd0, rx_data},  32'h11);
    send_frame(8'h55, 1'b1, 1'b1);
    check_eq("t3_count",   {29'd0, rx_count}, 32'h4);
    check_eq("t3_overrun", {31'd0, overrun},  32'h0);
    pop_check("t3_pop1", 8'h22);
    pop_check("t3_pop2", 8'h33);
    pop_check("t3_pop3", 8'h44);
    pop_check("t3_pop4", 8'h55);
    check_eq("t3_empty", {29'd0, rx_count}, 32'h0);

    // 4: two-cycle low glitch is rejected, receiver stays usable
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(20);
    check_eq("t4_count", {29'd0, rx_count},  32'h0);
    check_eq("t4_valid", {31'd0, rx_valid},  32'h0);
    check_eq("t4_ovr",   {31'd0, overrun},   32'h0);
    check_eq("t4_ferr",  {31'd0, frame_err}, 32'h0);
    send_frame(8'h5A, 1'b1, 1'b0);
    pop_check("t4_after_glitch", 8'h5A);

    // 5: low stop bit
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(20);
    check_eq("t5_ferr",  {31'd0, frame_err}, 32'h1);
    check_eq("t5_count", {29'd0, rx_count},  32'h0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("t5_ferr_clr", {31'd0, frame_err}, 32'h0);

    // 6: reset in the middle of bit 4 with a byte already queued
    send_frame(8'h99, 1'b1, 1'b0);
    check_eq("t6_pre_count", {29'd0, rx_count}, 32'h1);
    begin
      logic [7:0] pb;
      pb  = 8'hC3;
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
        rxd = pb[i];
        tick(CPB);
      end
      rxd = pb[4];
      tick(CPB / 2);
    end
    rst = 1'b1;
    rxd = 1'b1;
    tick(2);
    rst = 1'b0;
    check_all_zero("t6_reset");
    tick(4);
    send_frame(8'h7E, 1'b1, 1'b0);
    check_eq("t6_count", {29'd0, rx_count}, 32'h1);
    pop_check("t6_data", 8'h7E);
    check_eq("t6_ferr", {31'd0, frame_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
